// File: rtl/sd_spi_pkg.sv
// Shared constants, FSM state type and captured-command payload for the SD SPI-mode responder.
package sd_spi_pkg;

  localparam int unsigned CMD_W = 6;
  localparam int unsigned ARG_W = 32;
  localparam int unsigned BUF_W = 40;
  localparam int unsigned LEN_W = 3;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned GAP_W = 6;

  localparam logic [CMD_W-1:0] CMD_GO_IDLE       = 6'd0;
  localparam logic [CMD_W-1:0] CMD_SEND_IF_COND  = 6'd8;
  localparam logic [CMD_W-1:0] CMD_SET_BLOCKLEN  = 6'd16;
  localparam logic [CMD_W-1:0] CMD_APP           = 6'd55;
  localparam logic [CMD_W-1:0] CMD_READ_OCR      = 6'd58;
  localparam logic [CMD_W-1:0] CMD_CRC_ON_OFF    = 6'd59;
  localparam logic [CMD_W-1:0] ACMD_SEND_OP_COND = 6'd41;

  localparam int unsigned R1_IDLE     = 0;
  localparam int unsigned R1_ILLEGAL  = 2;
  localparam int unsigned R1_CRC_ERR  = 3;

  localparam logic [LEN_W-1:0] LEN_R1   = 3'd1;
  localparam logic [LEN_W-1:0] LEN_LONG = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_GAP,
    ST_SEND
  } state_e;

  typedef struct packed {
    logic             ok;
    logic [CMD_W-1:0] index;
    logic [11:0]      arg_lo;
  } cmd_t;

  function automatic logic [7:0] make_r1(input logic crc_err, input logic illegal,
                                         input logic idle);
    logic [7:0] r;
    r             = 8'h00;
    r[R1_CRC_ERR] = crc_err;
    r[R1_ILLEGAL] = illegal;
    r[R1_IDLE]    = idle;
    return r;
  endfunction

endpackage

// File: rtl/sd_resp_shifter.sv
// Response serialiser: loads up to 5 bytes and presents one bit per SPI falling edge, MSB first.
module sd_resp_shifter
  import sd_spi_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             fall_i,
  input  logic [BUF_W-1:0] data_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             do_o,
  output logic             done_o
);

  logic [BUF_W-1:0] sr_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] byte_q;
  logic [2:0]       bit_q;
  logic             do_q;
  logic             done_q;

  // done_q rises together with the last bit; the following strobe returns DO to idle-high
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sr_q   <= '0;
      len_q  <= '0;
      byte_q <= '0;
      bit_q  <= '0;
      do_q   <= 1'b1;
      done_q <= 1'b0;
    end else if (clear_i) begin
      len_q  <= '0;
      byte_q <= '0;
      bit_q  <= '0;
      do_q   <= 1'b1;
      done_q <= 1'b0;
    end else if (load_i) begin
      sr_q   <= data_i;
      len_q  <= len_i;
      byte_q <= '0;
      bit_q  <= '0;
      do_q   <= 1'b1;
      done_q <= 1'b0;
    end else if (fall_i) begin
      if (done_q) begin
        do_q <= 1'b1;
      end else begin
        do_q  <= sr_q[BUF_W-1];
        sr_q  <= {sr_q[BUF_W-2:0], 1'b1};
        bit_q <= bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          byte_q <= byte_q + 3'd1;
          if (byte_q + 3'd1 == len_q) done_q <= 1'b1;
        end
      end
    end
  end

  assign do_o   = do_q;
  assign done_o = done_q;

endmodule

// File: rtl/sd_spi_responder.sv
// SD SPI-mode card responder: decodes commands, tracks card state, serialises R1/R3/R7 onto io_DO.
// Define SD_ACMD41_DELAY_EN to answer INIT_POLLS ACMD41 polls as busy before completing init.
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter int unsigned NCR_BYTES  = 1,
  parameter int unsigned INIT_POLLS = 2,
  parameter logic [31:0] OCR_VALUE  = 32'h80FF8000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_SPI_CLK,
  input  logic             io_SPI_CS,
  input  logic             io_ArgumentReadFinished,
  input  logic             io_ReadSuccess,
  input  logic [CMD_W-1:0] io_Command,
  input  logic [ARG_W-1:0] io_CommandArgument,
  output logic             io_DO,
  output logic             io_Busy,
  output logic             io_CardIdle
);

`ifdef SD_ACMD41_DELAY_EN
  localparam int unsigned Polls = INIT_POLLS;
`else
  // INIT_POLLS has no effect: the first ACMD41 completes initialisation
  localparam int unsigned Polls = 0 * INIT_POLLS;
`endif
  localparam logic [GAP_W-1:0] GapLast = GAP_W'(NCR_BYTES * 8 - 1);

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] init_q, init_d;
  logic             idle_q, idle_d;
  logic             app_q, app_d;
  logic             busy_q, busy_d;
  logic             spi_q, arf_q;

  logic             fall_c, accept_c;
  logic             load_c, clear_c, shift_c, sh_done;
  logic             dec_idle, dec_app, dec_crc, dec_illegal;
  logic [CNT_W-1:0] dec_init;
  logic [31:0]      dec_tail;
  logic [LEN_W-1:0] dec_len;
  logic [BUF_W-1:0] dec_buf;
  logic             unused_arg;

  assign unused_arg = ^io_CommandArgument[ARG_W-1:12];
  assign fall_c     = spi_q & ~io_SPI_CLK;
  assign accept_c   = io_ArgumentReadFinished & ~arf_q & ~io_SPI_CS & (state_q == ST_IDLE);

  // Response contents and resulting card state for the captured command
  always_comb begin
    dec_idle    = idle_q;
    dec_app     = 1'b0;
    dec_init    = init_q;
    dec_crc     = 1'b0;
    dec_illegal = 1'b0;
    dec_tail    = '0;
    dec_len     = LEN_R1;
    if (!cmd_q.ok) begin
      dec_crc = 1'b1;
      dec_app = app_q;
    end else begin
      case (cmd_q.index)
        CMD_GO_IDLE: begin
          dec_idle = 1'b1;
          dec_init = CNT_W'(Polls);
        end
        CMD_SEND_IF_COND: begin
          dec_len  = LEN_LONG;
          dec_tail = {16'h0000, 4'h0, cmd_q.arg_lo};
        end
        CMD_APP: dec_app = 1'b1;
        ACMD_SEND_OP_COND: begin
          if (!app_q)             dec_illegal = 1'b1;
          else if (init_q != '0)  dec_init    = init_q - CNT_W'(1);
          else                    dec_idle    = 1'b0;
        end
        CMD_READ_OCR: begin
          dec_len  = LEN_LONG;
          dec_tail = OCR_VALUE;
        end
        CMD_SET_BLOCKLEN, CMD_CRC_ON_OFF: dec_len = LEN_R1;
        default: dec_illegal = 1'b1;
      endcase
    end
    dec_buf = {make_r1(dec_crc, dec_illegal, dec_idle), dec_tail};
  end

  // Next-state logic; CS deassertion aborts any transfer in progress
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    gap_d   = gap_q;
    init_d  = init_q;
    idle_d  = idle_q;
    app_d   = app_q;
    load_c  = 1'b0;
    clear_c = 1'b0;
    shift_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d      = ST_DECODE;
          cmd_d.ok     = io_ReadSuccess;
          cmd_d.index  = io_Command;
          cmd_d.arg_lo = io_CommandArgument[11:0];
        end
      end
      ST_DECODE: begin
        state_d = ST_GAP;
        load_c  = 1'b1;
        gap_d   = '0;
        idle_d  = dec_idle;
        app_d   = dec_app;
        init_d  = dec_init;
      end
      ST_GAP: begin
        if (fall_c) begin
          if (gap_q == GapLast) begin
            state_d = ST_SEND;
            shift_c = 1'b1;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      ST_SEND: begin
        if (fall_c) begin
          shift_c = 1'b1;
          if (sh_done) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (io_SPI_CS && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      load_c  = 1'b0;
      shift_c = 1'b0;
      clear_c = 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      gap_q   <= '0;
      init_q  <= CNT_W'(Polls);
      idle_q  <= 1'b1;
      app_q   <= 1'b0;
      busy_q  <= 1'b0;
      spi_q   <= 1'b0;
      arf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      gap_q   <= gap_d;
      init_q  <= init_d;
      idle_q  <= idle_d;
      app_q   <= app_d;
      busy_q  <= busy_d;
      spi_q   <= io_SPI_CLK;
      arf_q   <= io_ArgumentReadFinished;
    end
  end

  sd_resp_shifter u_shifter (
    .clock   (clock),
    .reset   (reset),
    .load_i  (load_c),
    .clear_i (clear_c),
    .fall_i  (shift_c),
    .data_i  (dec_buf),
    .len_i   (dec_len),
    .do_o    (io_DO),
    .done_o  (sh_done)
  );

  assign io_Busy     = busy_q;
  assign io_CardIdle = idle_q;

endmodule
